// File: rtl/cap_pkg.sv
// Shared types and constants for the capture controller.
// Build option: define CAPTURE_AUTO_TRIG_EN to enable the forced-trigger timeout in capture_ctrl.
package cap_pkg;

  localparam int NUM_CH = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    POST = 2'd2,
    DONE = 2'd3
  } cap_state_t;

endpackage

// File: rtl/cap_addr_ctr.sv
// Wrapping write-address counter for the circular capture buffer.
// The address space is a power of two, so plain AW-bit overflow gives the wrap.
module cap_addr_ctr #(
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  output logic [AW-1:0] addr
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr <= '0;
    end else if (inc) begin
      addr <= addr + AW'(1);
    end
  end

endmodule

// File: rtl/capture_ctrl.sv
// Capture sequencer: pre-trigger fill, trigger qualification, post-trigger count, done.
// Build option CAPTURE_AUTO_TRIG_EN adds a forced trigger after TIMEOUT armed strobes and the auto_trig output.
module capture_ctrl
  import cap_pkg::*;
#(
  parameter int DEPTH   = 512,
  parameter int AW      = $clog2(DEPTH),
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] ch_trig,
  input  logic              prot_trig,
  input  logic              start,
  input  logic              clr_done,
  input  logic [AW-1:0]     trig_pos,
  input  logic              smpl_en,
  output logic              armed,
  output logic              triggered,
  output logic              wrt_en,
  output logic [AW-1:0]     waddr,
  output logic [AW-1:0]     trig_addr,
  output logic              capture_done
`ifdef CAPTURE_AUTO_TRIG_EN
  ,
  output logic              auto_trig
`endif
);

  cap_state_t    state;
  logic [AW-1:0] trig_pos_q;
  logic [AW-1:0] post_cnt;
  logic [AW:0]   pre_cnt;
  logic [AW:0]   pre_target;
  logic [AW-1:0] next_addr;
  logic          trig_all;
  logic          fire;
  logic          start_ok;
  logic          last_post;

  assign trig_all  = (&ch_trig) & prot_trig;
  assign start_ok  = start & ((state == IDLE) | (state == DONE));
  assign next_addr = waddr + AW'(1);
  assign last_post = (post_cnt == (trig_pos_q - AW'(1)));

  // Pre-trigger fill target; one bit wider so trig_pos=0 asks for a full DEPTH of history.
  assign pre_target = (AW+1)'(DEPTH) - {1'b0, trig_pos_q};

  // A zero post-trigger length means POST passes straight through without writing.
  assign wrt_en = smpl_en & ((state == PRE) | ((state == POST) & (trig_pos_q != '0)));

  cap_addr_ctr #(
    .AW(AW)
  ) u_addr_ctr (
    .clk (clk),
    .rst (rst),
    .inc (wrt_en),
    .addr(waddr)
  );

`ifdef CAPTURE_AUTO_TRIG_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] to_cnt;
  logic          force_trig;

  assign force_trig = (to_cnt == TW'(TIMEOUT));
  assign fire       = armed & (trig_all | force_trig);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (state != PRE) begin
      to_cnt <= '0;
    end else if (armed && smpl_en && !force_trig) begin
      to_cnt <= to_cnt + TW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      auto_trig <= 1'b0;
    end else if (start_ok) begin
      auto_trig <= 1'b0;
    end else if ((state == PRE) && armed && force_trig) begin
      auto_trig <= 1'b1;
    end
  end
`else
  logic unused_timeout;

  assign fire           = armed & trig_all;
  assign unused_timeout = (TIMEOUT > 0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      armed        <= 1'b0;
      triggered    <= 1'b0;
      capture_done <= 1'b0;
      trig_addr    <= '0;
      trig_pos_q   <= '0;
      pre_cnt      <= '0;
      post_cnt     <= '0;
    end else if (start_ok) begin
      // Start beats a simultaneous clr_done; waddr keeps running from where it stopped.
      state        <= PRE;
      trig_pos_q   <= trig_pos;
      pre_cnt      <= '0;
      armed        <= 1'b0;
      triggered    <= 1'b0;
      capture_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          armed <= 1'b0;
        end
        PRE: begin
          if (fire) begin
            state     <= POST;
            triggered <= 1'b1;
            armed     <= 1'b0;
            post_cnt  <= '0;
            // A sample written on the trigger cycle belongs to the pre-trigger history.
            trig_addr <= smpl_en ? next_addr : waddr;
          end else begin
            if (smpl_en && (pre_cnt != pre_target)) begin
              pre_cnt <= pre_cnt + (AW+1)'(1);
            end
            if (pre_cnt == pre_target) begin
              armed <= 1'b1;
            end
          end
        end
        POST: begin
          if (trig_pos_q == '0) begin
            state        <= DONE;
            capture_done <= 1'b1;
          end else if (smpl_en) begin
            if (last_post) begin
              state        <= DONE;
              capture_done <= 1'b1;
            end else begin
              post_cnt <= post_cnt + AW'(1);
            end
          end
        end
        DONE: begin
          if (clr_done) begin
            state        <= IDLE;
            capture_done <= 1'b0;
            triggered    <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_capture_ctrl.sv
// Directed self-checking bench for capture_ctrl at DEPTH=16 (TIMEOUT=20 when CAPTURE_AUTO_TRIG_EN is set).
module tb_capture_ctrl;

  localparam int DEPTH   = 16;
  localparam int AW      = 4;
  localparam int TIMEOUT = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    ch_trig;
  logic          prot_trig;
  logic          start;
  logic          clr_done;
  logic [AW-1:0] trig_pos;
  logic          smpl_en;
  logic          armed;
  logic          triggered;
  logic          wrt_en;
  logic [AW-1:0] waddr;
  logic [AW-1:0] trig_addr;
  logic          capture_done;
`ifdef CAPTURE_AUTO_TRIG_EN
  logic          auto_trig;
`endif

  int            n_pass = 0;
  int            n_total = 0;
  int            wr_cnt = 0;
  int            base;
  logic [AW-1:0] exp_waddr;
  logic [AW-1:0] exp_trig;

  capture_ctrl #(
    .DEPTH  (DEPTH),
    .AW     (AW),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ch_trig     (ch_trig),
    .prot_trig   (prot_trig),
    .start       (start),
    .clr_done    (clr_done),
    .trig_pos    (trig_pos),
    .smpl_en     (smpl_en),
    .armed       (armed),
    .triggered   (triggered),
    .wrt_en      (wrt_en),
    .waddr       (waddr),
    .trig_addr   (trig_addr),
    .capture_done(capture_done)
`ifdef CAPTURE_AUTO_TRIG_EN
    ,
    .auto_trig   (auto_trig)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  // Count RAM writes that will land on the coming rising edge.
  always @(negedge clk) begin
    if (wrt_en) wr_cnt++;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [AW-1:0] tp);
    start    = 1'b1;
    trig_pos = tp;
    tick();
    start    = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_done = 1'b1;
    tick();
    clr_done = 1'b0;
  endtask

  task automatic wait_armed();
    bit seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      tick();
      seen = armed;
    end
    if (!seen) begin
      n_total++;
      $display("FAIL wait_armed: armed=0 after 100 cycles, expected 1");
    end
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      tick();
      seen = capture_done;
    end
    if (!seen) begin
      n_total++;
      $display("FAIL wait_done: capture_done=0 after 100 cycles, expected 1");
    end
  endtask

  // scenarios
  task automatic test_reset();
    rst = 1'b1; ch_trig = '0; prot_trig = 1'b0; start = 1'b0;
    clr_done = 1'b0; trig_pos = '0; smpl_en = 1'b1;
    tick(); tick();
    n_total++; if ({armed, triggered, wrt_en, capture_done} !== 4'b0000) $display("FAIL reset_flags: got %b expected 0000", {armed, triggered, wrt_en, capture_done}); else n_pass++;
    n_total++; if (waddr !== 4'd0) $display("FAIL reset_waddr: got %0d expected 0", waddr); else n_pass++;
    n_total++; if (trig_addr !== 4'd0) $display("FAIL reset_trig_addr: got %0d expected 0", trig_addr); else n_pass++;
    rst = 1'b0;
    tick();
    n_total++; if (wrt_en !== 1'b0) $display("FAIL idle_no_write: got %b expected 0", wrt_en); else n_pass++;
    exp_waddr = 4'd0;
  endtask

  task automatic test_basic();
    ch_trig = 5'h1F; prot_trig = 1'b1; smpl_en = 1'b1;
    base = wr_cnt;
    pulse_start(4'd4);
    n_total++; if (armed !== 1'b0) $display("FAIL basic_armed_early: got %b expected 0", armed); else n_pass++;
    wait_armed();
    // 12 fill writes plus the one made on the edge that raises armed
    n_total++; if (wr_cnt - base !== 13) $display("FAIL basic_arm_writes: got %0d expected 13", wr_cnt - base); else n_pass++;
    tick();
    exp_trig = exp_waddr + AW'(14);
    n_total++; if ({triggered, armed} !== 2'b10) $display("FAIL basic_trig_flags: got %b expected 10", {triggered, armed}); else n_pass++;
    n_total++; if (trig_addr !== exp_trig) $display("FAIL basic_trig_addr: got %0d expected %0d", trig_addr, exp_trig); else n_pass++;
    base = wr_cnt;
    wait_done();
    n_total++; if (wr_cnt - base !== 4) $display("FAIL basic_post_writes: got %0d expected 4", wr_cnt - base); else n_pass++;
    n_total++; if (waddr !== exp_trig + AW'(4)) $display("FAIL basic_final_waddr: got %0d expected %0d", waddr, exp_trig + AW'(4)); else n_pass++;
    n_total++; if (wrt_en !== 1'b0) $display("FAIL basic_done_no_write: got %b expected 0", wrt_en); else n_pass++;
    pulse_clr();
    n_total++; if ({capture_done, triggered} !== 2'b00) $display("FAIL basic_clr: got %b expected 00", {capture_done, triggered}); else n_pass++;
    exp_waddr = exp_trig + AW'(4);
  endtask

  task automatic test_early_trig();
    ch_trig = 5'h1F; prot_trig = 1'b0; smpl_en = 1'b1;
    base = wr_cnt;
    pulse_start(4'd4);
    for (int i = 0; i < 50 && (wr_cnt - base) < 5; i++) tick();
    prot_trig = 1'b1;
    tick();
    prot_trig = 1'b0;
    n_total++; if ({triggered, armed} !== 2'b00) $display("FAIL early_ignored: got %b expected 00", {triggered, armed}); else n_pass++;
    wait_armed();
    n_total++; if (wr_cnt - base !== 13) $display("FAIL early_arm_writes: got %0d expected 13", wr_cnt - base); else n_pass++;
    prot_trig = 1'b1;
    tick();
    prot_trig = 1'b0;
    exp_trig = exp_waddr + AW'(14);
    n_total++; if (triggered !== 1'b1) $display("FAIL early_late_trig: got %b expected 1", triggered); else n_pass++;
    n_total++; if (trig_addr !== exp_trig) $display("FAIL early_trig_addr: got %0d expected %0d", trig_addr, exp_trig); else n_pass++;
    wait_done();
    n_total++; if (waddr !== exp_trig + AW'(4)) $display("FAIL early_final_waddr: got %0d expected %0d", waddr, exp_trig + AW'(4)); else n_pass++;
    pulse_clr();
    exp_waddr = exp_trig + AW'(4);
  endtask

  task automatic test_trig_pos_15();
    prot_trig = 1'b1; smpl_en = 1'b1;
    base = wr_cnt;
    pulse_start(4'd15);
    wait_armed();
    n_total++; if (wr_cnt - base !== 2) $display("FAIL tp15_arm_writes: got %0d expected 2", wr_cnt - base); else n_pass++;
    tick();
    exp_trig = exp_waddr + AW'(3);
    n_total++; if (trig_addr !== exp_trig) $display("FAIL tp15_trig_addr: got %0d expected %0d", trig_addr, exp_trig); else n_pass++;
    wait_done();
    n_total++; if (waddr !== exp_trig + AW'(15)) $display("FAIL tp15_final_waddr: got %0d expected %0d", waddr, exp_trig + AW'(15)); else n_pass++;
    pulse_clr();
    exp_waddr = exp_trig + AW'(15);
  endtask

  task automatic test_trig_pos_0();
    prot_trig = 1'b1; smpl_en = 1'b1;
    base = wr_cnt;
    pulse_start(4'd0);
    wait_armed();
    n_total++; if (wr_cnt - base !== 17) $display("FAIL tp0_arm_writes: got %0d expected 17", wr_cnt - base); else n_pass++;
    smpl_en = 1'b0;
    tick();
    exp_trig = exp_waddr + AW'(1);
    n_total++; if (trig_addr !== exp_trig) $display("FAIL tp0_trig_addr_no_smpl: got %0d expected %0d", trig_addr, exp_trig); else n_pass++;
    smpl_en = 1'b1;
    #1;
    n_total++; if (wrt_en !== 1'b0) $display("FAIL tp0_post_no_write: got %b expected 0", wrt_en); else n_pass++;
    tick();
    n_total++; if (capture_done !== 1'b1) $display("FAIL tp0_done_next_edge: got %b expected 1", capture_done); else n_pass++;
    n_total++; if (wr_cnt - base !== 17) $display("FAIL tp0_total_writes: got %0d expected 17", wr_cnt - base); else n_pass++;
    n_total++; if (waddr !== exp_trig) $display("FAIL tp0_final_waddr: got %0d expected %0d", waddr, exp_trig); else n_pass++;
    pulse_clr();
    exp_waddr = exp_trig;
  endtask

  task automatic test_wrap();
    bit positioned = 1'b0;
    prot_trig = 1'b0; smpl_en = 1'b1;
    pulse_start(4'd8);
    // Hold off the trigger until the write pointer sits at 14.
    for (int i = 0; i < 80 && !positioned; i++) begin
      tick();
      positioned = armed && (waddr == 4'd14);
    end
    if (!positioned) begin
      n_total++;
      $display("FAIL wrap_position: armed=%b waddr=%0d, expected armed=1 waddr=14", armed, waddr);
    end
    prot_trig = 1'b1;
    tick();
    prot_trig = 1'b0;
    n_total++; if (trig_addr !== 4'd15) $display("FAIL wrap_trig_addr: got %0d expected 15", trig_addr); else n_pass++;
    base = wr_cnt;
    wait_done();
    n_total++; if (wr_cnt - base !== 8) $display("FAIL wrap_post_writes: got %0d expected 8", wr_cnt - base); else n_pass++;
    n_total++; if (waddr !== 4'd7) $display("FAIL wrap_final_waddr: got %0d expected 7", waddr); else n_pass++;
    pulse_clr();
    exp_waddr = 4'd7;
  endtask

  task automatic test_start_in_post();
    prot_trig = 1'b1; smpl_en = 1'b1;
    pulse_start(4'd6);
    wait_armed();
    tick();
    exp_trig = exp_waddr + AW'(12);
    n_total++; if (trig_addr !== exp_trig) $display("FAIL post_start_trig_addr: got %0d expected %0d", trig_addr, exp_trig); else n_pass++;
    base = wr_cnt;
    tick();
    pulse_start(4'd1);
    n_total++; if ({triggered, capture_done} !== 2'b10) $display("FAIL post_start_ignored: got %b expected 10", {triggered, capture_done}); else n_pass++;
    wait_done();
    n_total++; if (wr_cnt - base !== 6) $display("FAIL post_start_writes: got %0d expected 6", wr_cnt - base); else n_pass++;
    n_total++; if (waddr !== exp_trig + AW'(6)) $display("FAIL post_start_waddr: got %0d expected %0d", waddr, exp_trig + AW'(6)); else n_pass++;
  endtask

  task automatic test_start_clr_same();
    start = 1'b1; clr_done = 1'b1; trig_pos = 4'd4;
    tick();
    start = 1'b0; clr_done = 1'b0;
    n_total++; if ({capture_done, triggered} !== 2'b00) $display("FAIL restart_flags: got %b expected 00", {capture_done, triggered}); else n_pass++;
    n_total++; if (wrt_en !== 1'b1) $display("FAIL restart_in_pre: got %b expected 1", wrt_en); else n_pass++;
  endtask

  task automatic test_reset_mid_post();
    prot_trig = 1'b1; smpl_en = 1'b1;
    wait_armed();
    tick();
    tick();
    n_total++; if (triggered !== 1'b1) $display("FAIL rst_pre_post: got %b expected 1", triggered); else n_pass++;
    #2;
    rst = 1'b1;
    #1;
    n_total++; if ({armed, triggered, wrt_en, capture_done} !== 4'b0000) $display("FAIL rst_async_flags: got %b expected 0000", {armed, triggered, wrt_en, capture_done}); else n_pass++;
    n_total++; if ({waddr, trig_addr} !== 8'h00) $display("FAIL rst_async_addr: got %h expected 00", {waddr, trig_addr}); else n_pass++;
    tick();
    rst = 1'b0;
    tick();
    n_total++; if (wrt_en !== 1'b0) $display("FAIL rst_idle_after: got %b expected 0", wrt_en); else n_pass++;
    exp_waddr = 4'd0;
  endtask

`ifdef CAPTURE_AUTO_TRIG_EN
  task automatic test_auto_trig();
    bit early = 1'b0;
    ch_trig = 5'h1F; prot_trig = 1'b0; smpl_en = 1'b1;
    pulse_start(4'd4);
    wait_armed();
    for (int i = 0; i < TIMEOUT; i++) begin
      tick();
      if (triggered) early = 1'b1;
    end
    n_total++; if (early !== 1'b0) $display("FAIL auto_early: got %b expected 0", early); else n_pass++;
    tick();
    exp_trig = exp_waddr + AW'(13 + TIMEOUT + 1);
    n_total++; if ({triggered, auto_trig} !== 2'b11) $display("FAIL auto_fire: got %b expected 11", {triggered, auto_trig}); else n_pass++;
    n_total++; if (trig_addr !== exp_trig) $display("FAIL auto_trig_addr: got %0d expected %0d", trig_addr, exp_trig); else n_pass++;
    wait_done();
    n_total++; if (waddr !== exp_trig + AW'(4)) $display("FAIL auto_final_waddr: got %0d expected %0d", waddr, exp_trig + AW'(4)); else n_pass++;
    pulse_start(4'd4);
    n_total++; if (auto_trig !== 1'b0) $display("FAIL auto_clear_on_start: got %b expected 0", auto_trig); else n_pass++;
  endtask
`else
  task automatic test_no_auto_trig();
    bit fired = 1'b0;
    ch_trig = 5'h1F; prot_trig = 1'b0; smpl_en = 1'b1;
    pulse_start(4'd4);
    wait_armed();
    for (int i = 0; i < 40; i++) begin
      tick();
      if (triggered) fired = 1'b1;
    end
    n_total++; if (fired !== 1'b0) $display("FAIL no_auto_waits: got %b expected 0", fired); else n_pass++;
    n_total++; if (armed !== 1'b1) $display("FAIL no_auto_still_armed: got %b expected 1", armed); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_early_trig();
    test_trig_pos_15();
    test_trig_pos_0();
    test_wrap();
    test_start_in_post();
    test_start_clr_same();
    test_reset_mid_post();
`ifdef CAPTURE_AUTO_TRIG_EN
    test_auto_trig();
`else
    test_no_auto_trig();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
